// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: one grant at a time, held until done or request drop.
// Optional grant timeout is compiled in with RR_ARBITER8_TIMEOUT_EN (uses HOLD_MAX).
module rr_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [2:0] r_gnt_idx, w_idx_nxt;
    logic       r_gnt_valid, w_vld_nxt;
    logic [7:0] r_gnt_onehot;
    logic       r_busy;

    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_off;
    logic [2:0]  w_pick;
    logic        w_tmo;
    logic        w_release;

    // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
    assign w_dbl  = {req, req};
    assign w_rot  = w_dbl[r_ptr +: 8];
    assign w_pick = r_ptr + w_off;

    always_comb begin
        w_off = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (w_rot[j]) w_off = 3'(j);
        end
    end

`ifdef RR_ARBITER8_TIMEOUT_EN
    logic [3:0] r_hold;

    // Cleared on the granting edge, so it reads k-1 during the k-th grant cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_hold <= 4'd0;
        else if (r_state == IDLE)
            r_hold <= 4'd0;
        else
            r_hold <= r_hold + 4'd1;
    end

    assign w_tmo = (r_state == GRANT) && (r_hold == 4'(HOLD_MAX - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_release = done || !req[r_gnt_idx] || w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_gnt_idx;
        w_vld_nxt   = r_gnt_valid;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_pick;
                    w_vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_vld_nxt   = 1'b0;
                    w_ptr_nxt   = r_gnt_idx + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= 3'd0;
            r_gnt_idx    <= 3'd0;
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gnt_idx    <= w_idx_nxt;
            r_gnt_valid  <= w_vld_nxt;
            r_gnt_onehot <= w_vld_nxt ? (8'h01 << w_idx_nxt) : 8'h00;
            r_busy       <= (w_state_nxt == GRANT);
        end
    end

    assign gnt_valid  = r_gnt_valid;
    assign gnt_idx    = r_gnt_idx;
    assign gnt_onehot = r_gnt_onehot;
    assign busy       = r_busy;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, giving the maximum grant duration in cycles (1..15); it is used only when the configuration macro is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8 bits: request lines; req[n] high means requester n wants the shared resource.
REQ-005 The block SHALL have port done, input, 1 bit: the granted requester signals completion.
REQ-006 The block SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-007 The block SHALL have port gnt_idx, output, 3 bits: binary index of the granted requester.
REQ-008 The block SHALL have port gnt_onehot, output, 8 bits: one-hot form of gnt_idx, all zero when gnt_valid is 0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while the FSM is in GRANT.

Function
REQ-010 The FSM SHALL have two states, IDLE and GRANT; all outputs SHALL be registered or decoded only from registered state.
REQ-011 The block SHALL keep a 3-bit rotating pointer ptr that marks the highest-priority requester for the next arbitration.
REQ-012 In IDLE with req != 0, the block SHALL select the first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8), register it in gnt_idx, set gnt_valid, and enter GRANT on the same edge, giving 1-cycle latency from req sampled to gnt_valid high.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt_valid=0 and hold gnt_idx at its last value.
REQ-014 In GRANT, the block SHALL release the grant when done=1 or when req[gnt_idx]=0; on the releasing edge it SHALL clear gnt_valid, set ptr to gnt_idx+1 (mod 8, so 7 wraps to 0) and enter IDLE.
REQ-015 There SHALL be at least one cycle with gnt_valid=0 between consecutive grants, including a re-grant to the same requester.
REQ-016 In GRANT, changes on non-granted req bits SHALL have no effect; the grant is never preempted by another requester.
REQ-017 done SHALL be ignored in IDLE.
REQ-018 If done and req[gnt_idx] fall together, the block SHALL perform a single release with one ptr update.
REQ-019 gnt_onehot SHALL equal 1<<gnt_idx when gnt_valid=1 and 8'h00 otherwise; gnt_idx encodes gnt_onehot exactly as an 8-to-3 encoder would.

Reset
REQ-020 When rst=1 on a rising edge, the block SHALL set state=IDLE, ptr=0, gnt_valid=0, gnt_idx=0, gnt_onehot=0, busy=0 and hold counter=0, with rst taking priority over every other input.
REQ-021 A reset asserted mid-grant SHALL drop gnt_valid in the cycle after the reset edge, and the first arbitration after reset SHALL start from ptr=0.

Configuration
REQ-022 When macro RR_ARBITER8_TIMEOUT_EN is defined, a 4-bit hold counter SHALL clear on grant, increment each GRANT cycle, and force a release (identical to a done release, ptr advances) on the edge where the grant has been valid HOLD_MAX cycles.
REQ-023 When RR_ARBITER8_TIMEOUT_EN is undefined, the counter logic SHALL be absent and a grant SHALL be held until done or its req is deasserted.

Verification
REQ-024 Single request: after reset, req=8'h10 -> gnt_valid=1, gnt_idx=4, gnt_onehot=8'h10 one cycle later; then done=1 -> gnt_valid=0 next cycle and ptr=5.
REQ-025 Round-robin fairness: req=8'hFF held, with done pulsed one cycle after each grant -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-026 Pointer wrap: grant idx 7, release, then req=8'h81 -> next grant is idx 0, not 7.
REQ-027 No preemption and request drop: grant idx 2, raise req[1] -> idx 2 kept; then drop req[2] -> release; next grant is idx 1 only after the ptr search passes 3..7 and wraps to 0..1.
REQ-028 Reset mid-grant: grant idx 5, assert rst for one cycle -> all outputs 0; req=8'h21 -> grant idx 0.
REQ-029 Timeout (macro defined, HOLD_MAX=3): req=8'h08 held, done=0 -> gnt_valid high exactly 3 cycles, low 1 cycle, then re-granted to idx 3; with macro undefined -> gnt_valid stays high indefinitely.
